// File: rtl/unet_ctrl_pkg.sv
// Shared definitions for the U-Net control-register AXI4-Lite responder:
// register offsets, CC bit positions, response codes and FSM state types.
package unet_ctrl_pkg;

    localparam logic [15:0] ID_OFS = 16'h0000;
    localparam logic [15:0] CC_OFS = 16'h3000;
    localparam logic [15:0] SP_OFS = 16'h4000;

    localparam int unsigned CC_START    = 0;
    localparam int unsigned CC_DONE     = 1;
    localparam int unsigned CC_BUSY     = 2;
    localparam int unsigned CC_IRQ_MASK = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_DATA } rd_state_t;

    typedef enum logic [1:0] { REG_ID, REG_CC, REG_SP, REG_NONE } reg_sel_t;

    // Word-address decode; byte offset bits [1:0] are already dropped.
    function automatic reg_sel_t decode(input logic [13:0] word);
        if (word == ID_OFS[15:2]) return REG_ID;
        if (word == CC_OFS[15:2]) return REG_CC;
        if (word == SP_OFS[15:2]) return REG_SP;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/unet_ctrl_axil_slave_if.sv
// AXI4-Lite bus bundle between the PS-side master and the control-register responder.
interface unet_ctrl_axil_slave_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/unet_ctrl_regs.sv
// Control register bank: ID (RO), CC (START pulse, sticky DONE, BUSY, optional
// IRQ_MASK) and SP (byte-writable base address). Optional interrupt output is
// enabled by defining UNET_AXIL_IRQ_EN.
module unet_ctrl_regs
    import unet_ctrl_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h554E_0001,
    parameter logic [31:0] SP_RESET = 32'h4580_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [13:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic [1:0]  wr_resp,
    input  logic [13:0] rd_addr,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_resp,
    input  logic        busy,
    input  logic        done_pulse,
    output logic        start,
    output logic [31:0] base_addr
`ifdef UNET_AXIL_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic [31:0] sp;
    logic        done_flag;
    logic        cc_hit;
    logic        sp_hit;

    assign cc_hit    = wr_en && (decode(wr_addr) == REG_CC);
    assign sp_hit    = wr_en && (decode(wr_addr) == REG_SP);
    assign base_addr = sp;
    assign wr_resp   = (decode(wr_addr) == REG_NONE) ? RESP_SLVERR : RESP_OKAY;

    // SP storage with per-byte strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= SP_RESET;
        end else if (sp_hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_strb[i]) sp[8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // START pulse (suppressed while busy) and sticky DONE; a new done wins over W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start     <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            start     <= cc_hit && wr_data[CC_START] && !busy;
            done_flag <= done_pulse || (done_flag && !(cc_hit && wr_data[CC_DONE]));
        end
    end

`ifdef UNET_AXIL_IRQ_EN
    logic irq_mask;

    // IRQ mask register and registered interrupt output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (cc_hit) irq_mask <= wr_data[CC_IRQ_MASK];
            irq <= done_flag && irq_mask;
        end
    end
`endif

    // Read mux; unmapped offsets return zero with SLVERR.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (decode(rd_addr))
            REG_ID: rd_data = ID_VALUE;
            REG_CC: begin
                rd_data[CC_DONE] = done_flag;
                rd_data[CC_BUSY] = busy;
`ifdef UNET_AXIL_IRQ_EN
                rd_data[CC_IRQ_MASK] = irq_mask;
`endif
            end
            REG_SP:  rd_data = sp;
            default: rd_resp = RESP_SLVERR;
        endcase
    end

endmodule

// File: rtl/unet_ctrl_axil_slave.sv
// AXI4-Lite responder for the U-Net accelerator control registers.
// Holds the write (AW/W -> B) and read (AR -> R) handshake FSMs; the register
// bank lives in unet_ctrl_regs. Define UNET_AXIL_IRQ_EN to add irq_o.
module unet_ctrl_axil_slave
    import unet_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] ID_VALUE = 32'h554E_0001,
    parameter logic [31:0] SP_RESET = 32'h4580_0000
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    unet_ctrl_axil_slave_if.slave        Unet_S00_AXI,
    output logic                         start_o,
    output logic [31:0]                  base_addr_o,
    input  logic                         busy_i,
    input  logic                         done_i
`ifdef UNET_AXIL_IRQ_EN
    ,
    output logic                         irq_o
`endif
);

    wr_state_t   wr_state;
    rd_state_t   rd_state;
    logic        aw_have;
    logic        w_have;
    logic [13:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_take;
    logic        w_take;
    logic        ar_take;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [1:0]  wr_resp;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        unused_bits;

    assign unused_bits = ^{Unet_S00_AXI.awprot, Unet_S00_AXI.arprot,
                           Unet_S00_AXI.awaddr[ADDR_W-1:16], Unet_S00_AXI.awaddr[1:0],
                           Unet_S00_AXI.araddr[ADDR_W-1:16], Unet_S00_AXI.araddr[1:0]};

    assign aw_take = (wr_state == W_IDLE) && Unet_S00_AXI.awvalid && Unet_S00_AXI.awready;
    assign w_take  = (wr_state == W_IDLE) && Unet_S00_AXI.wvalid && Unet_S00_AXI.wready;
    assign ar_take = (rd_state == R_IDLE) && Unet_S00_AXI.arvalid && Unet_S00_AXI.arready;

    // Commit uses a beat taken this cycle directly, so the update lands on the
    // same edge that completes the AW/W pair and bvalid follows one cycle later.
    assign wr_addr = aw_have ? aw_addr_q : Unet_S00_AXI.awaddr[15:2];
    assign wr_data = w_have ? w_data_q : Unet_S00_AXI.wdata;
    assign wr_strb = w_have ? w_strb_q : Unet_S00_AXI.wstrb;
    assign wr_en   = (wr_state == W_IDLE) && (aw_have || aw_take) && (w_have || w_take);

    // Write channel FSM: collect AW and W in any order, commit, hold B until bready.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state             <= W_IDLE;
            aw_have              <= 1'b0;
            w_have               <= 1'b0;
            aw_addr_q            <= '0;
            w_data_q             <= '0;
            w_strb_q             <= '0;
            Unet_S00_AXI.awready <= 1'b1;
            Unet_S00_AXI.wready  <= 1'b1;
            Unet_S00_AXI.bvalid  <= 1'b0;
            Unet_S00_AXI.bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_take) begin
                        aw_have              <= 1'b1;
                        aw_addr_q            <= Unet_S00_AXI.awaddr[15:2];
                        Unet_S00_AXI.awready <= 1'b0;
                    end
                    if (w_take) begin
                        w_have              <= 1'b1;
                        w_data_q            <= Unet_S00_AXI.wdata;
                        w_strb_q            <= Unet_S00_AXI.wstrb;
                        Unet_S00_AXI.wready <= 1'b0;
                    end
                    if (wr_en) begin
                        wr_state            <= W_RESP;
                        Unet_S00_AXI.bvalid <= 1'b1;
                        Unet_S00_AXI.bresp  <= wr_resp;
                    end
                end
                W_RESP: begin
                    if (Unet_S00_AXI.bready) begin
                        wr_state             <= W_IDLE;
                        aw_have              <= 1'b0;
                        w_have               <= 1'b0;
                        Unet_S00_AXI.bvalid  <= 1'b0;
                        Unet_S00_AXI.awready <= 1'b1;
                        Unet_S00_AXI.wready  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: capture data at the AR handshake, hold R until rready.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state             <= R_IDLE;
            Unet_S00_AXI.arready <= 1'b1;
            Unet_S00_AXI.rvalid  <= 1'b0;
            Unet_S00_AXI.rdata   <= '0;
            Unet_S00_AXI.rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_take) begin
                        rd_state             <= R_DATA;
                        Unet_S00_AXI.arready <= 1'b0;
                        Unet_S00_AXI.rvalid  <= 1'b1;
                        Unet_S00_AXI.rdata   <= rd_data;
                        Unet_S00_AXI.rresp   <= rd_resp;
                    end
                end
                R_DATA: begin
                    if (Unet_S00_AXI.rready) begin
                        rd_state             <= R_IDLE;
                        Unet_S00_AXI.rvalid  <= 1'b0;
                        Unet_S00_AXI.arready <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    unet_ctrl_regs #(
        .ID_VALUE (ID_VALUE),
        .SP_RESET (SP_RESET)
    ) u_regs (
        .clk        (ACLK),
        .rst        (ARESET),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .wr_resp    (wr_resp),
        .rd_addr    (Unet_S00_AXI.araddr[15:2]),
        .rd_data    (rd_data),
        .rd_resp    (rd_resp),
        .busy       (busy_i),
        .done_pulse (done_i),
        .start      (start_o),
        .base_addr  (base_addr_o)
`ifdef UNET_AXIL_IRQ_EN
        ,
        .irq        (irq_o)
`endif
    );

endmodule

// File: tb/tb_unet_ctrl_axil_slave.sv
// Self-checking bench for unet_ctrl_axil_slave: expected B/R responses are queued
// when a transaction is issued and compared when the DUT completes the handshake.
module tb_unet_ctrl_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start_o;
    logic [31:0] base_addr_o;
    logic        busy_i = 1'b0;
    logic        done_i = 1'b0;
`ifdef UNET_AXIL_IRQ_EN
    logic        irq_o;
`endif

    always #5 ACLK = ~ACLK;

    unet_ctrl_axil_slave_if bus ();

    unet_ctrl_axil_slave dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .Unet_S00_AXI (bus),
        .start_o      (start_o),
        .base_addr_o  (base_addr_o),
        .busy_i       (busy_i),
        .done_i       (done_i)
`ifdef UNET_AXIL_IRQ_EN
        ,
        .irq_o        (irq_o)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Response scoreboard: a handshake completes on the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (start_o) start_cnt++;
            if (bus.bvalid && bus.bready) begin
                if (wq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
                else begin
                    e = wq.pop_front();
                    check({e.tag, "_bresp"}, {30'd0, bus.bresp}, {30'd0, e.resp});
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
                else begin
                    e = rq.pop_front();
                    check({e.tag, "_rresp"}, {30'd0, bus.rresp}, {30'd0, e.resp});
                    check({e.tag, "_rdata"}, bus.rdata, e.data);
                end
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        while (!bus.awready && n < 50) begin tick(); n++; end
        if (n >= 50) check("aw_timeout", 32'd0, 32'd1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin tick(); n++; end
        if (n >= 50) check("w_timeout", 32'd0, 32'd1);
        tick();
        bus.wvalid = 1'b0;
    endtask

    task automatic wait_wr_idle();
        int n = 0;
        while (!(bus.awready && bus.wready) && n < 50) begin tick(); n++; end
        if (n >= 50) check("wr_idle_timeout", 32'd0, 32'd1);
    endtask

    // W lags AW by 'lag' cycles; bvalid must be up one cycle after the last beat.
    task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lag, input logic [1:0] resp);
        exp_t e;
        e.tag = tag; e.data = '0; e.resp = resp;
        wq.push_back(e);
        fork
            send_aw(a);
            begin
                repeat (lag) tick();
                send_w(d, s);
            end
        join
        check({tag, "_blat"}, {31'd0, bus.bvalid}, 32'd1);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] resp);
        exp_t e;
        int n = 0;
        e.tag = tag; e.data = d; e.resp = resp;
        rq.push_back(e);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 50) begin tick(); n++; end
        if (n >= 50) check("ar_timeout", 32'd0, 32'd1);
        tick();
        bus.arvalid = 1'b0;
        check({tag, "_rlat"}, {31'd0, bus.rvalid}, 32'd1);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_awready"}, {31'd0, bus.awready}, 32'd1);
        check({tag, "_wready"},  {31'd0, bus.wready},  32'd1);
        check({tag, "_arready"}, {31'd0, bus.arready}, 32'd1);
        check({tag, "_bvalid"},  {31'd0, bus.bvalid},  32'd0);
        check({tag, "_rvalid"},  {31'd0, bus.rvalid},  32'd0);
        check({tag, "_bresp"},   {30'd0, bus.bresp},   32'd0);
        check({tag, "_rresp"},   {30'd0, bus.rresp},   32'd0);
        check({tag, "_rdata"},   bus.rdata,            32'd0);
        check({tag, "_start"},   {31'd0, start_o},     32'd0);
        check({tag, "_base"},    base_addr_o,          32'h4580_0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;

        repeat (3) tick();
        ARESET = 1'b0;
        tick();
        check_reset_state("rst");

        // Partial strobe from reset value.
        axi_write("sp_strb", 32'h4000, 32'h1234_5678, 4'b0011, 0, 2'b00);
        check("sp_strb_base", base_addr_o, 32'h4580_5678);

        // AW leads W by 3 cycles.
        axi_write("sp_full", 32'h4000, 32'hDEAD_BEEF, 4'hF, 3, 2'b00);
        check("sp_full_base", base_addr_o, 32'hDEAD_BEEF);
        axi_read("sp_rd", 32'h4000, 32'hDEAD_BEEF, 2'b00);
        axi_read("sp_rd_lsb", 32'h4003, 32'hDEAD_BEEF, 2'b00);

        // START pulse, then START while busy.
        wait_wr_idle();
        sc = start_cnt;
        axi_write("cc_start", 32'h3000, 32'h1, 4'hF, 0, 2'b00);
        check("start_hi", {31'd0, start_o}, 32'd1);
        tick();
        check("start_lo", {31'd0, start_o}, 32'd0);
        repeat (3) tick();
        check("start_cnt", start_cnt - sc, 32'd1);
        busy_i = 1'b1;
        sc = start_cnt;
        axi_write("cc_start_busy", 32'h3000, 32'h1, 4'hF, 0, 2'b00);
        check("start_busy", {31'd0, start_o}, 32'd0);
        repeat (3) tick();
        check("start_busy_cnt", start_cnt - sc, 32'd0);
        axi_read("cc_busy_rd", 32'h3000, 32'h4, 2'b00);
        busy_i = 1'b0;
        axi_read("cc_idle_rd", 32'h3000, 32'h0, 2'b00);

        // Sticky DONE and W1C collision.
        pulse_done();
        axi_read("cc_done_rd", 32'h3000, 32'h2, 2'b00);
        wait_wr_idle();
        fork
            axi_write("cc_w1c_race", 32'h3000, 32'h2, 4'hF, 0, 2'b00);
            pulse_done();
        join
        axi_read("cc_race_rd", 32'h3000, 32'h2, 2'b00);
        axi_write("cc_w1c", 32'h3000, 32'h2, 4'hF, 0, 2'b00);
        axi_read("cc_clr_rd", 32'h3000, 32'h0, 2'b00);

        // Unmapped offsets and ID.
        axi_read("bad_rd", 32'h2000, 32'h0, 2'b10);
        axi_write("bad_wr", 32'h5000, 32'hFFFF_FFFF, 4'hF, 0, 2'b10);
        check("bad_wr_base", base_addr_o, 32'hDEAD_BEEF);
        axi_read("sp_after_bad", 32'h4000, 32'hDEAD_BEEF, 2'b00);
        axi_read("cc_after_bad", 32'h3000, 32'h0, 2'b00);
        axi_read("id_rd", 32'h0000, 32'h554E_0001, 2'b00);
        axi_write("id_wr", 32'h0000, 32'h0, 4'hF, 0, 2'b00);
        axi_read("id_rd2", 32'h0000, 32'h554E_0001, 2'b00);

        // Same-cycle read and write of SP returns the old value.
        wait_wr_idle();
        repeat (2) tick();
        fork
            axi_write("sp_same_wr", 32'h4000, 32'h1111_1111, 4'hF, 0, 2'b00);
            axi_read("sp_same_rd", 32'h4000, 32'hDEAD_BEEF, 2'b00);
        join
        axi_read("sp_new_rd", 32'h4000, 32'h1111_1111, 2'b00);

        // Backpressure: responses and payloads stay stable.
        repeat (2) tick();
        bus.bready = 1'b0;
        axi_write("sp_hold", 32'h4000, 32'hA5A5_A5A5, 4'hF, 0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bhold_valid", {31'd0, bus.bvalid}, 32'd1);
            check("bhold_resp", {30'd0, bus.bresp}, 32'd0);
        end
        bus.bready = 1'b1;
        bus.rready = 1'b0;
        axi_read("sp_rhold", 32'h4000, 32'hA5A5_A5A5, 2'b00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rhold_valid", {31'd0, bus.rvalid}, 32'd1);
            check("rhold_data", bus.rdata, 32'hA5A5_A5A5);
        end
        bus.rready = 1'b1;
        repeat (2) tick();

        // Reset while both responses are pending.
        pulse_done();
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        fork
            axi_write("rst_wr", 32'h4000, 32'h0BAD_F00D, 4'hF, 0, 2'b00);
            axi_read("rst_rd", 32'h0000, 32'h554E_0001, 2'b00);
        join
        tick();
        ARESET = 1'b1;
        #1;
        check_reset_state("midrst");
        wq.delete();
        rq.delete();
        tick();
        ARESET = 1'b0;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        repeat (3) tick();
        axi_read("post_rst_cc", 32'h3000, 32'h0, 2'b00);
        axi_read("post_rst_sp", 32'h4000, 32'h4580_0000, 2'b00);

`ifdef UNET_AXIL_IRQ_EN
        check("irq_rst", {31'd0, irq_o}, 32'd0);
        axi_write("irq_mask", 32'h3000, 32'h8, 4'hF, 0, 2'b00);
        axi_read("irq_mask_rd", 32'h3000, 32'h8, 2'b00);
        pulse_done();
        check("irq_lag", {31'd0, irq_o}, 32'd0);
        tick();
        check("irq_set", {31'd0, irq_o}, 32'd1);
`endif

        repeat (5) tick();
        check("wq_empty", wq.size(), 32'd0);
        check("rq_empty", rq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
